// File: rtl/mlp_host_driver.sv
// Hardware bus initiator for the mlp accelerator slave port. It pushes the input vector
// and the weight set from a synchronous ROM, starts the run, polls for completion and
// returns the signed result.
module mlp_host_driver #(
  parameter int unsigned N_INPUTS  = 2,
  parameter int unsigned N_HIDDEN  = 4,
  parameter int unsigned N_OUTPUT  = 1,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned WGT_WIDTH = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 1024,
  localparam int unsigned NHW = N_HIDDEN * (N_INPUTS + 1),
  localparam int unsigned NOW = N_OUTPUT * (N_HIDDEN + 1),
  localparam int unsigned NW  = NHW + NOW,
  localparam int unsigned AW  = $clog2(NW),
  localparam int unsigned CW  = $clog2(TIMEOUT + NW + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_INPUTS*IN_WIDTH-1:0] in_vec,
  output logic [AW-1:0]                rom_addr,
  input  logic [WGT_WIDTH-1:0]         rom_rdata,
  output logic                         mlp_write_en,
  output logic [1:0]                   mlp_addr,
  output logic [31:0]                  mlp_writedata,
  input  logic [31:0]                  mlp_readdata,
  input  logic                         mlp_irq,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  output logic [OUT_WIDTH-1:0]         result
);

  typedef enum logic [3:0] {
    StIdle, StWrIn, StWrHw, StWrSel, StWrOw, StWrRun, StPoll, StRdA, StRdB, StFin
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [N_INPUTS*IN_WIDTH-1:0] in_q;
  logic                         timeout_err_q;
  logic                         timeout_set;
  logic [OUT_WIDTH-1:0]         result_q;
  logic [IN_WIDTH-1:0]          in_sel;
  logic [31:0]                  in_ext;
  logic [31:0]                  wgt_ext;
  logic                         unused_rd;

  assign unused_rd   = ^mlp_readdata[31:OUT_WIDTH];
  assign timeout_err = timeout_err_q;
  assign result      = result_q;
  assign in_ext      = {{(32 - IN_WIDTH){in_sel[IN_WIDTH-1]}}, in_sel};
  assign wgt_ext     = {{(32 - WGT_WIDTH){rom_rdata[WGT_WIDTH-1]}}, rom_rdata};

  // State register plus per-state cycle counter (cleared on every state change).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode; POLL ignores the stale readdata of its first cycle.
  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StWrIn;
      StWrIn:  if (cnt_q == CW'(N_INPUTS - 1)) state_d = StWrHw;
      StWrHw:  if (cnt_q == CW'(NHW - 1)) state_d = StWrSel;
      StWrSel: state_d = StWrOw;
      StWrOw:  if (cnt_q == CW'(NOW - 1)) state_d = StWrRun;
      StWrRun: state_d = StPoll;
      StPoll: begin
        if ((cnt_q != '0 && mlp_readdata[1]) || mlp_irq) begin
          state_d = StRdA;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = StFin;
          timeout_set = 1'b1;
        end
      end
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q || state_q == StIdle) ? '0 : cnt_q + CW'(1);
  end

  // Input latch, sticky timeout flag and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q          <= '0;
      timeout_err_q <= 1'b0;
      result_q      <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        in_q          <= in_vec;
        timeout_err_q <= 1'b0;
      end
      if (timeout_set) timeout_err_q <= 1'b1;
      if (state_q == StRdB) result_q <= mlp_readdata[OUT_WIDTH-1:0];
    end
  end

  // Select the input element for the current WR_IN beat.
  always_comb begin
    in_sel = '0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      if (cnt_q == CW'(k)) in_sel = in_q[k*IN_WIDTH +: IN_WIDTH];
    end
  end

  // Bus and ROM outputs; the ROM address always runs one beat ahead of the write.
  always_comb begin
    mlp_write_en  = 1'b0;
    mlp_addr      = 2'd0;
    mlp_writedata = '0;
    rom_addr      = '0;
    busy          = (state_q != StIdle);
    done          = 1'b0;
    unique case (state_q)
      StWrIn: begin
        mlp_write_en  = 1'b1;
        mlp_addr      = 2'd1;
        mlp_writedata = in_ext;
      end
      StWrHw: begin
        mlp_write_en  = 1'b1;
        mlp_addr      = 2'd2;
        mlp_writedata = wgt_ext;
        rom_addr      = AW'(cnt_q) + AW'(1);
      end
      StWrSel: begin
        mlp_write_en  = 1'b1;
        mlp_writedata = 32'h8;
        rom_addr      = AW'(NHW);
      end
      StWrOw: begin
        mlp_write_en  = 1'b1;
        mlp_addr      = 2'd2;
        mlp_writedata = wgt_ext;
        // Last beat has nothing left to prefetch; hold the address in range.
        rom_addr      = (cnt_q == CW'(NOW - 1)) ? AW'(NW - 1) : AW'(NHW) + AW'(cnt_q) + AW'(1);
      end
      StWrRun: begin
        mlp_write_en  = 1'b1;
        mlp_writedata = 32'h1;
      end
      StRdA, StRdB: mlp_addr = 2'd3;
      StFin:        done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mlp_host_driver.sv
// Self-checking bench for mlp_host_driver: ROM and mlp slave models, a write/result
// scoreboard and an MLP reference computed directly from the input vector and ROM.
module tb_mlp_host_driver;
  localparam int NI = 2, NH = 4, IW = 16, NHW = 12, NW = 17, TO = 1024, WRITES = 21;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] in_vec = '0;
  logic [4:0]  rom_addr;
  logic [15:0] rom_rdata = '0;
  logic        mlp_write_en, mlp_irq = 1'b0, busy, done, timeout_err;
  logic [1:0]  mlp_addr;
  logic [31:0] mlp_writedata, mlp_readdata = '0;
  logic [15:0] result;

  mlp_host_driver dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .mlp_write_en(mlp_write_en), .mlp_addr(mlp_addr), .mlp_writedata(mlp_writedata),
    .mlp_readdata(mlp_readdata), .mlp_irq(mlp_irq),
    .busy(busy), .done(done), .timeout_err(timeout_err), .result(result)
  );

  always #5 clk = ~clk;

  int                 n_checks = 0, n_fail = 0;
  logic [33:0]        exp_q[$];
  logic [16:0]        res_q[$];
  logic signed [15:0] rom[NW];
  int                 done_delay = -1, irq_k = -1, rd3_cnt = 0;
  logic [31:0]        in_fifo[$], w_fifo[$];
  logic [31:0]        out_val = '0;
  logic [15:0]        last_res = '0;
  bit                 s_running = 0, s_done = 0;
  int                 s_rc = 0;
  logic               sn_we = 1'b0;
  logic [1:0]         sn_addr = '0;
  logic [31:0]        sn_wd = '0;
  logic [4:0]         sn_rom = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: hidden = relu(b + sum w*x), output = b + sum w*h, low 16 bits.
  function automatic logic [15:0] ref_mlp(input logic [31:0] x);
    longint xi[NI];
    longint h[NH];
    longint acc;
    for (int i = 0; i < NI; i++) xi[i] = longint'($signed(x[i*IW +: IW]));
    for (int j = 0; j < NH; j++) begin
      acc = longint'(rom[j*(NI+1)]);
      for (int i = 0; i < NI; i++) acc += longint'(rom[j*(NI+1)+1+i]) * xi[i];
      h[j] = (acc < 0) ? 0 : acc;
    end
    acc = longint'(rom[NHW]);
    for (int j = 0; j < NH; j++) acc += longint'(rom[NHW+1+j]) * h[j];
    return acc[15:0];
  endfunction

  // Slave-side evaluation of whatever actually arrived through the FIFOs.
  function automatic logic [31:0] slave_eval();
    longint h[NH];
    longint acc;
    if (in_fifo.size() != NI || w_fifo.size() != NW) return 32'hDEAD_BEEF;
    for (int j = 0; j < NH; j++) begin
      acc = longint'($signed(w_fifo[j*(NI+1)]));
      for (int i = 0; i < NI; i++)
        acc += longint'($signed(w_fifo[j*(NI+1)+1+i])) * longint'($signed(in_fifo[i]));
      h[j] = (acc < 0) ? 0 : acc;
    end
    acc = longint'($signed(w_fifo[NHW]));
    for (int j = 0; j < NH; j++) acc += longint'($signed(w_fifo[NHW+1+j])) * h[j];
    return acc[31:0];
  endfunction

  function automatic void push_trace(input logic [31:0] x);
    logic signed [15:0] e;
    for (int i = 0; i < NI; i++) begin
      e = x[i*IW +: IW];
      exp_q.push_back({2'd1, 32'(e)});
    end
    for (int k = 0; k < NHW; k++) exp_q.push_back({2'd2, 32'(rom[k])});
    exp_q.push_back({2'd0, 32'h8});
    for (int k = NHW; k < NW; k++) exp_q.push_back({2'd2, 32'(rom[k])});
    exp_q.push_back({2'd0, 32'h1});
  endfunction

  // ROM and slave models: outputs are snapshotted at negedge and acted on at posedge.
  initial forever begin
    @(negedge clk);
    sn_we = (mlp_write_en === 1'b1); sn_addr = mlp_addr; sn_wd = mlp_writedata; sn_rom = rom_addr;
    @(posedge clk);
    rom_rdata <= (sn_rom < NW) ? rom[sn_rom] : 16'hxxxx;
    if (rst) begin
      s_running = 0; s_done = 0; s_rc = 0;
      in_fifo.delete(); w_fifo.delete();
      mlp_irq <= 1'b0; mlp_readdata <= '0;
    end else begin
      if (s_running) s_rc++;
      if (sn_we) begin
        case (sn_addr)
          2'd0: if (sn_wd[0]) begin
            out_val = slave_eval();
            in_fifo.delete(); w_fifo.delete();
            s_running = 1; s_rc = 0; s_done = 0;
          end
          2'd1: in_fifo.push_back(sn_wd);
          2'd2: w_fifo.push_back(sn_wd);
          default: ;
        endcase
      end
      if (s_running && done_delay >= 0 && s_rc >= done_delay) s_done = 1;
      mlp_irq <= s_running && irq_k >= 0 && s_rc == irq_k;
      case (sn_addr)
        2'd0:    mlp_readdata <= {30'd0, s_done, s_running};
        2'd3:    mlp_readdata <= out_val;
        default: mlp_readdata <= '0;
      endcase
    end
  end

  // Scoreboard monitor: every write and every done pulse pops an expected entry.
  initial forever begin
    @(negedge clk);
    if (mlp_addr == 2'd3) rd3_cnt++;
    check("rom_addr_in_range", rom_addr < NW, 1);
    if (mlp_write_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected none", mlp_addr,
                 mlp_writedata);
      end else check("write_trace", {mlp_addr, mlp_writedata}, exp_q.pop_front());
    end
    if (done === 1'b1) begin
      if (res_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=1, expected 0");
      end else check("run_result", {timeout_err, result}, res_q.pop_front());
    end
  end

  task automatic run(input logic [31:0] x, input int dd, input int ik, input bit hold,
                     input bit keep, input bit chained);
    int n, e, exp_lat;
    bit to;
    logic [15:0] er;
    done_delay = dd; irq_k = ik;
    to = (dd < 0 && ik < 0);
    e = (dd < 0) ? 1 << 30 : ((dd < 1) ? 1 : dd);
    if (ik >= 0 && ik < e) e = ik;
    exp_lat = to ? WRITES + TO + 1 : WRITES + e + 1 + 3;
    er = to ? last_res : ref_mlp(x);
    push_trace(x);
    res_q.push_back({to, er});
    rd3_cnt = 0;
    if (!chained) begin
      @(posedge clk); #1; in_vec = x; start = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0; in_vec = $urandom;
    end
    n = 1;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk); n++;
    end
    check("start_to_done_latency", n, exp_lat);
    if (to) check("no_addr3_on_timeout", rd3_cnt, 0);
    if (!keep) start = 1'b0;
    last_res = er;
    @(negedge clk);
    check("done_single_pulse", done, 0);
    check("idle_after_fin", busy, 0);
    check("timeout_err_held", timeout_err, to);
    check("result_held", result, er);
    check("trace_drained", exp_q.size(), 0);
  endtask

  task automatic rand_setup(output logic [31:0] x);
    for (int k = 0; k < NW; k++) rom[k] = 16'($urandom_range(127)) - 16'd64;
    x = {16'($urandom_range(511)) - 16'd256, 16'($urandom_range(511)) - 16'd256};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] x;
    int k, guard;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_write_en", mlp_write_en, 0);
    check("rst_addr", mlp_addr, 0);
    check("rst_writedata", mlp_writedata, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_result", result, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Nominal: in_vec = [7, -3], fixed ROM, DONE 10 cycles after RUN.
    for (int i = 0; i < NW; i++) rom[i] = 16'(i * 7 - 50);
    run({16'hFFFD, 16'h0007}, 10, -1, 0, 0, 0);
    // Minimum latency and irq-only exit.
    rand_setup(x); run(x, 0, -1, 0, 0, 0);
    rand_setup(x); run(x, -1, 5, 0, 0, 0);
    // Timeout keeps the previous result, then a good run clears the flag.
    rand_setup(x); run(x, -1, -1, 0, 0, 0);
    rand_setup(x); run(x, 3, -1, 0, 0, 0);

    // Reset in the middle of the hidden-weight writes.
    rand_setup(x);
    push_trace(x);
    @(posedge clk); #1; in_vec = x; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 0; guard = 0;
    while (k < 8 && guard < 100) begin
      @(negedge clk); guard++;
      if (mlp_write_en === 1'b1) k++;
    end
    check("writes_before_reset", k, 8);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_write_en", mlp_write_en, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_addr", mlp_addr, 0);
    check("midrun_rst_writedata", mlp_writedata, 0);
    check("midrun_rst_rom_addr", rom_addr, 0);
    check("midrun_rst_result", result, 0);
    exp_q.delete(); res_q.delete(); last_res = '0;
    @(posedge clk); #1; rst = 1'b0;
    rand_setup(x); run(x, 2, -1, 0, 0, 0);

    // Start held through a run: one run only, then stays idle once start drops.
    rand_setup(x); run(x, 4, -1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("no_requeued_run", busy, 0);
    end
    // Start still high in IDLE: a new run follows.
    rand_setup(x); run(x, 1, -1, 1, 1, 0);
    run(x, 6, -1, 0, 0, 1);

    // Random mix of DONE delays and irq pulses.
    for (int r = 0; r < 6; r++) begin
      rand_setup(x);
      run(x, int'($urandom_range(15)), ($urandom_range(1) == 1) ? int'($urandom_range(12, 1)) : -1,
          0, 0, 0);
    end

    repeat (3) @(negedge clk);
    check("final_scoreboard_empty", exp_q.size() + res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_host_driver.md
# mlp_host_driver

Bus-initiator that drives the `mlp` accelerator's 4-register slave port (`write_en`/`addr`/`writedata`/`readdata`/`irq`) in hardware. On `start` it pushes an input vector and the full weight set, read from a synchronous weight ROM, into the accelerator. It then starts the run, polls for completion and returns the signed result. It sits between the system sequencer and `mlp`, replacing software or testbench register programming.

## Interface
- `N_INPUTS`, 2, input vector length
- `N_HIDDEN`, 4, hidden neurons
- `N_OUTPUT`, 1, output neurons
- `IN_WIDTH`, 16, input element width (signed)
- `WGT_WIDTH`, 16, weight/bias width (signed)
- `OUT_WIDTH`, 16, result width (signed)
- `TIMEOUT`, 1024, max POLL cycles before abort
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `in_vec`  in  N_INPUTS*IN_WIDTH  element k at `[k*IN_WIDTH +: IN_WIDTH]`; latched on accepted `start`
- `rom_addr`  out  $clog2(NW)  weight ROM address, NW = N_HIDDEN*(N_INPUTS+1)+N_OUTPUT*(N_HIDDEN+1)
- `rom_rdata`  in  WGT_WIDTH  ROM data, valid one cycle after `rom_addr`
- `mlp_write_en`  out  1  slave write strobe
- `mlp_addr`  out  2  slave address: 0 CTRL, 1 input FIFO, 2 weight FIFO, 3 output
- `mlp_writedata`  out  32  slave write data
- `mlp_readdata`  in  32  slave read data, registered: reflects `mlp_addr` of previous cycle
- `mlp_irq`  in  1  slave completion interrupt
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run (success or timeout)
- `timeout_err`  out  1  valid with `done`; held until next accepted `start`
- `result`  out  OUT_WIDTH  signed result; held until next successful run

## Operation
- ROM layout: hidden neuron h occupies addresses h*(N_INPUTS+1) (bias), followed by its N_INPUTS weights. Output weights start at NHW = N_HIDDEN*(N_INPUTS+1), with the same bias-first order.
- All written values are sign-extended to 32 bits.
- CTRL bits: 0 RUN, 1 DONE, 3 LAYER_SEL.
- FSM states and per-state behaviour:
  - IDLE: `start`=1 latches `in_vec`, clears `timeout_err`, goes to WR_IN.
  - WR_IN: N_INPUTS cycles. `write_en`=1, addr 1, data = input[k]. `rom_addr`=0 throughout, to prefetch.
  - WR_HW: NHW cycles. `write_en`=1, addr 2, data = `rom_rdata`. In cycle k, `rom_addr`=k+1.
  - WR_SEL: 1 cycle. `write_en`=1, addr 0, data 0x8. `rom_addr`=NHW.
  - WR_OW: N_OUTPUT*(N_HIDDEN+1) cycles. Weight FIFO writes from `rom_rdata`. In cycle k, `rom_addr`=NHW+k+1.
  - WR_RUN: 1 cycle. `write_en`=1, addr 0, data 0x1.
  - POLL: `write_en`=0, addr 0, one-cycle settling counter.
    - The first POLL cycle's `readdata` is stale and is ignored.
    - Exit to RD_A on `readdata[1]`=1 or `mlp_irq`=1.
    - After TIMEOUT POLL cycles, go to FIN with `timeout_err`=1.
  - RD_A: addr 3, `write_en`=0.
  - RD_B: addr 3, `write_en`=0. Samples `readdata[OUT_WIDTH-1:0]` into `result`.
  - FIN: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- Out-of-range `rom_addr` values (≥NW) are never driven. Clamp prefetch to NW-1 on the last WR_OW cycle.
- `start` while busy: ignored, no queuing.
- `mlp_writedata`=0 and `mlp_write_en`=0 in every non-write state.

## Timing
- Reset values: `mlp_write_en` 0, `mlp_addr` 0, `mlp_writedata` 0, `rom_addr` 0, `busy` 0, `done` 0, `timeout_err` 0, `result` 0. FSM state = IDLE.
- `rst` mid-run: state returns to IDLE at the next edge and all outputs take their reset values. No further slave writes occur; the slave is expected to be reset alongside.
- `start` sampled at edge E0: WR_IN is active in the cycle after E0.
- Write phase length = N_INPUTS+NHW+1+N_OUTPUT*(N_HIDDEN+1)+1 consecutive `write_en` cycles. The default is 21, with no gaps.
- Minimum POLL length is 2 cycles, when DONE is visible on the second.
- RD_A/RD_B: 2 cycles. FIN: 1 cycle.
- Default minimum latency from `start` to `done`: 21+2+2+1 = 26 cycles.
- The `result` update and `done` assertion are visible in the same cycle (FIN).

## Test plan
- Nominal run: `in_vec`=[7,−3], ROM holds 17 known weights, slave model asserts DONE 10 cycles after RUN.
  - Required: write trace 7, 0xFFFFFFFD, ROM[0..11] to addr 2, 0x8 to addr 0, ROM[12..16], 0x1 to addr 0.
  - Required: `result` equals the reference MLP value and `done` pulses once.
- Minimum latency: slave asserts DONE immediately -> `done` exactly 26 cycles after `start`.
- Irq exit: DONE bit is never set, `mlp_irq` pulses 5 cycles into POLL -> RD_A follows on the next cycle and the run completes.
- Timeout: slave is never done -> after 1024 POLL cycles, `done`=1, `timeout_err`=1, `result` unchanged, and addr 3 is never read.
- Reset mid-WR_HW: `rst` at write 8 -> `mlp_write_en`=0 next cycle, `busy`=0. A following `start` produces a full fresh 21-write trace.
- `start` held high through a run -> exactly one run is performed. A new run starts the cycle after FIN only if `start` is still high in IDLE.
